// File: rtl/pixel_frame_capture.sv
// Pixel frame capture: buffers one num_pixels frame from a row/col-addressed ADC stream and
// drains it in raster order over a valid/ready port. Define PIXEL_CAPTURE_CHECKSUM_EN for frame_checksum_o.
package pixel_frame_capture_pkg;
    function automatic int isqrt(input int value);
        int root;
        root = 0;
        for (int r = 1; r * r <= value; r++) begin
            root = r;
        end
        return root;
    endfunction
endpackage

module pixel_frame_capture
    import pixel_frame_capture_pkg::*;
#(
    parameter int num_pixels = 4,
    parameter int data_width = 8,
    localparam int sideLen = isqrt(num_pixels),
    localparam int addrWidth = (sideLen > 1) ? $clog2(sideLen) : 1,
    localparam int indexWidth = (num_pixels > 1) ? $clog2(num_pixels) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  read_i,
    input  logic [addrWidth-1:0]  row_addr_i,
    input  logic [addrWidth-1:0]  col_addr_i,
    input  logic [data_width-1:0] pixel_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [data_width-1:0] out_data_o,
    output logic [indexWidth-1:0] out_index_o,
    output logic                  out_last_o,
    output logic                  frame_done_o,
    output logic                  short_frame_o,
    output logic                  overrun_o,
    output logic                  busy_o
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0]           frame_checksum_o
`endif
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;

    localparam logic [indexWidth:0]   fullCount = (indexWidth + 1)'(num_pixels);
    localparam logic [indexWidth-1:0] lastIndex = indexWidth'(num_pixels - 1);

    state_e                  state_q, state_d;
    logic [indexWidth:0]     count_q, count_d;
    logic [indexWidth-1:0]   rdPtr_q, rdPtr_d;
    logic                    frameDone_q, frameDone_d;
    logic                    shortFrame_q, shortFrame_d;
    logic                    overrun_q, overrun_d;
    logic [data_width-1:0]   buffer_q [num_pixels];

    logic [indexWidth-1:0]   wrAddr;
    logic                    addrInRange;
    logic                    writeEn;

    assign wrAddr      = indexWidth'(row_addr_i) * indexWidth'(sideLen) + indexWidth'(col_addr_i);
    assign addrInRange = {1'b0, wrAddr} < fullCount;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rdPtr_d      = rdPtr_q;
        frameDone_d  = 1'b0;
        shortFrame_d = 1'b0;
        overrun_d    = 1'b0;
        writeEn      = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_i) begin
                    writeEn = addrInRange;
                    count_d = (indexWidth + 1)'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (read_i) begin
                    writeEn = addrInRange;
                    count_d = (count_q == fullCount) ? count_q : count_q + (indexWidth + 1)'(1);
                end else if (count_q == fullCount) begin
                    frameDone_d = 1'b1;
                    rdPtr_d     = '0;
                    state_d     = DRAIN;
                end else begin
                    shortFrame_d = 1'b1;
                    count_d      = '0;
                    state_d      = IDLE;
                end
            end
            DRAIN: begin
                // Samples arriving while draining are dropped so the frame being streamed stays intact.
                overrun_d = read_i;
                if (out_ready_i) begin
                    if (rdPtr_q == lastIndex) begin
                        rdPtr_d = '0;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        rdPtr_d = rdPtr_q + indexWidth'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rdPtr_q      <= '0;
            frameDone_q  <= 1'b0;
            shortFrame_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rdPtr_q      <= rdPtr_d;
            frameDone_q  <= frameDone_d;
            shortFrame_q <= shortFrame_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame storage carries no reset; its contents are meaningless until a frame is captured.
    always_ff @(posedge clk_i) begin
        if (writeEn) begin
            buffer_q[wrAddr] <= pixel_data_i;
        end
    end

    assign out_valid_o   = (state_q == DRAIN);
    assign out_data_o    = buffer_q[rdPtr_q];
    assign out_index_o   = rdPtr_q;
    assign out_last_o    = (state_q == DRAIN) && (rdPtr_q == lastIndex);
    assign frame_done_o  = frameDone_q;
    assign short_frame_o = shortFrame_q;
    assign overrun_o     = overrun_q;
    assign busy_o        = (state_q != IDLE);

`ifdef PIXEL_CAPTURE_CHECKSUM_EN
    logic [15:0] frameSum;
    logic [15:0] checksum_q;

    always_comb begin
        frameSum = '0;
        for (int i = 0; i < num_pixels; i++) begin
            frameSum = frameSum + 16'(buffer_q[i]);
        end
    end

    // The buffer is complete on the CAPTURE->DRAIN edge, so the sum is latched alongside frame_done.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            checksum_q <= '0;
        end else if (frameDone_d) begin
            checksum_q <= frameSum;
        end
    end

    assign frame_checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Testbench for pixel_frame_capture: directed frames plus randomized traffic against a queue-based
// reference model. Define PIXEL_CAPTURE_CHECKSUM_EN to also check frame_checksum_o.
module tb_pixel_frame_capture;

    localparam int P    = 4;
    localparam int DW   = 8;
    localparam int SIDE = 2;

    typedef struct {
        int data;
        int idx;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetN;
    logic          read;
    logic [0:0]    rowAddr;
    logic [0:0]    colAddr;
    logic [DW-1:0] pixelData;
    logic          outReady;
    logic          outValid;
    logic [DW-1:0] outData;
    logic [1:0]    outIndex;
    logic          outLast;
    logic          frameDone;
    logic          shortFrame;
    logic          overrun;
    logic          busy;
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
    logic [15:0]   frameChecksum;
`endif

    int    assertionCount = 0;
    int    failCount = 0;
    beat_t drainQ[$];
    int    modelBuf[P];
    bit    capturing;
    int    sampleCount;
    bit    expFrameDone;
    bit    expShortFrame;
    bit    expOverrun;
    int    expChecksum;

    always #5 clk = ~clk;

    pixel_frame_capture #(.num_pixels(P), .data_width(DW)) dut (
        .clk_i(clk),
        .reset_n_i(resetN),
        .read_i(read),
        .row_addr_i(rowAddr),
        .col_addr_i(colAddr),
        .pixel_data_i(pixelData),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .out_data_o(outData),
        .out_index_o(outIndex),
        .out_last_o(outLast),
        .frame_done_o(frameDone),
        .short_frame_o(shortFrame),
        .overrun_o(overrun),
        .busy_o(busy)
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
        ,
        .frame_checksum_o(frameChecksum)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertionCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Reference model: a frame is a set of addressed samples; a finished frame becomes a queue of beats.
    task automatic modelUpdate();
        int sum;
        expFrameDone  = 1'b0;
        expShortFrame = 1'b0;
        expOverrun    = 1'b0;
        if (drainQ.size() != 0) begin
            if (read) expOverrun = 1'b1;
            if (outReady) drainQ.delete(0);
        end else if (capturing) begin
            if (read) begin
                modelBuf[rowAddr * SIDE + colAddr] = int'(pixelData);
                if (sampleCount < P) sampleCount++;
            end else if (sampleCount == P) begin
                expFrameDone = 1'b1;
                capturing    = 1'b0;
                sum          = 0;
                for (int i = 0; i < P; i++) begin
                    drainQ.push_back('{data: modelBuf[i], idx: i});
                    sum += modelBuf[i];
                end
                expChecksum = sum % 65536;
            end else begin
                expShortFrame = 1'b1;
                capturing     = 1'b0;
            end
        end else if (read) begin
            capturing   = 1'b1;
            sampleCount = 1;
            modelBuf[rowAddr * SIDE + colAddr] = int'(pixelData);
        end
    endtask

    task automatic modelReset();
        drainQ.delete();
        capturing     = 1'b0;
        sampleCount   = 0;
        expFrameDone  = 1'b0;
        expShortFrame = 1'b0;
        expOverrun    = 1'b0;
        expChecksum   = 0;
    endtask

    task automatic verifyCycle();
        checkOutput("out_valid", 32'(outValid), 32'(drainQ.size() != 0));
        checkOutput("out_last", 32'(outLast), 32'(drainQ.size() == 1));
        if (drainQ.size() != 0) begin
            checkOutput("out_data", 32'(outData), drainQ[0].data);
            checkOutput("out_index", 32'(outIndex), drainQ[0].idx);
        end
        checkOutput("busy", 32'(busy), 32'(capturing || drainQ.size() != 0));
        checkOutput("frame_done", 32'(frameDone), 32'(expFrameDone));
        checkOutput("short_frame", 32'(shortFrame), 32'(expShortFrame));
        checkOutput("overrun", 32'(overrun), 32'(expOverrun));
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
        checkOutput("frame_checksum", 32'(frameChecksum), expChecksum);
`endif
    endtask

    task automatic applyStimulus(input bit rd, input int addr, input int data, input bit rdy);
        read      = rd;
        rowAddr   = 1'(addr / SIDE);
        colAddr   = 1'(addr % SIDE);
        pixelData = DW'(data);
        outReady  = rdy;
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        verifyCycle();
    endtask

    task automatic runFrame(input int n, input int vals[8], input int addrs[8]);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, addrs[i], vals[i], 1'b1);
        applyStimulus(1'b0, 0, 0, 1'b1);
    endtask

    // mode 0: always ready, mode 1: ready pattern 1,0,0 repeating, mode 2: random ready and stray reads
    task automatic drainFrame(input int mode);
        int cycles;
        bit rdy;
        bit rd;
        cycles = 0;
        while (drainQ.size() != 0 && cycles < 60) begin
            rd  = 1'b0;
            rdy = 1'b1;
            if (mode == 1) rdy = (cycles % 3 == 0);
            if (mode == 2) begin
                rdy = 1'($urandom % 2);
                rd  = ($urandom % 4 == 0);
            end
            applyStimulus(rd, int'($urandom % P), int'($urandom % 256), rdy);
            cycles++;
        end
        checkOutput("drain_timeout", 32'(drainQ.size()), 32'd0);
    endtask

    task automatic doReset();
        #2;
        resetN   = 1'b0;
        read     = 1'b0;
        outReady = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_out_last", 32'(outLast), 32'd0);
        checkOutput("rst_out_index", 32'(outIndex), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_done", 32'(frameDone), 32'd0);
        checkOutput("rst_short_frame", 32'(shortFrame), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        int vals[8];
        int addrs[8];
        int seqAddrs[8];
        int n;
        int j;
        int tmp;

        resetN    = 1'b0;
        read      = 1'b0;
        rowAddr   = '0;
        colAddr   = '0;
        pixelData = '0;
        outReady  = 1'b0;
        modelReset();
        seqAddrs = '{0, 1, 2, 3, 0, 1, 2, 3};
        repeat (2) @(negedge clk);
        verifyCycle();
        resetN = 1'b1;
        applyStimulus(1'b0, 0, 0, 1'b0);

        $display("[TB] basic frame, ready held high");
        vals = '{10, 20, 30, 40, 0, 0, 0, 0};
        runFrame(4, vals, seqAddrs);
        drainFrame(0);

        $display("[TB] same frame, ready toggling");
        runFrame(4, vals, seqAddrs);
        drainFrame(1);

        $display("[TB] short frame");
        runFrame(3, vals, seqAddrs);
        repeat (2) applyStimulus(1'b0, 0, 0, 1'b1);

        $display("[TB] overrun during stalled drain");
        runFrame(4, vals, seqAddrs);
        applyStimulus(1'b1, 0, 99, 1'b0);
        applyStimulus(1'b1, 3, 77, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0);
        drainFrame(0);

        $display("[TB] reset during drain");
        runFrame(4, vals, seqAddrs);
        applyStimulus(1'b0, 0, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 1'b1);
        doReset();
        vals = '{1, 2, 3, 4, 0, 0, 0, 0};
        runFrame(4, vals, seqAddrs);
        drainFrame(0);

`ifdef PIXEL_CAPTURE_CHECKSUM_EN
        $display("[TB] checksum frames");
        vals = '{250, 250, 250, 250, 0, 0, 0, 0};
        runFrame(4, vals, seqAddrs);
        checkOutput("checksum_1000", 32'(frameChecksum), 32'd1000);
        drainFrame(0);
        vals = '{255, 255, 255, 255, 0, 0, 0, 0};
        runFrame(4, vals, seqAddrs);
        checkOutput("checksum_1020", 32'(frameChecksum), 32'd1020);
        drainFrame(1);
`endif

        $display("[TB] randomized frames");
        for (int iter = 0; iter < 150; iter++) begin
            for (int i = 0; i < 8; i++) begin
                addrs[i] = (i < P) ? i : int'($urandom % P);
                vals[i]  = int'($urandom % 256);
            end
            for (int i = P - 1; i > 0; i--) begin
                j        = int'($urandom_range(i, 0));
                tmp      = addrs[i];
                addrs[i] = addrs[j];
                addrs[j] = tmp;
            end
            if ($urandom % 5 == 0) begin
                n = int'($urandom_range(3, 1));
                runFrame(n, vals, addrs);
            end else begin
                n = P + int'($urandom % 3);
                runFrame(n, vals, addrs);
                if ($urandom % 15 == 0) begin
                    applyStimulus(1'b0, 0, 0, 1'($urandom % 2));
                    doReset();
                end else begin
                    drainFrame(int'($urandom % 3));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
        $finish;
    end

endmodule
